// File: rtl/shifter_operand_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shifter_loader_pkg
// Description : Shared types, button indices and switch field bounds for the
//               barrel-shifter operand loader.
// Revision    : 1.0 - initial release
// ============================================================================
package shifter_loader_pkg;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        HAVE_DATA = 2'd1,
        HAVE_CTRL = 2'd2,
        READY     = 2'd3
    } state_t;

    localparam int BTN_DATA  = 1;
    localparam int BTN_CTRL  = 2;
    localparam int BTN_CARRY = 3;
    localparam int BTN_CLR   = 4;

    localparam int OP_MSB_SW  = 1;
    localparam int OP_LSB_SW  = 3;
    localparam int NUM_MSB_SW = 9;
    localparam int NUM_LSB_SW = 16;

    // Only the load presses move the FSM; clear is handled by the caller.
    function automatic state_t load_next_state(state_t cur, logic ld_data, logic ld_ctrl);
        state_t nxt;
        nxt = cur;
        case (cur)
            EMPTY: begin
                if (ld_data && ld_ctrl) nxt = READY;
                else if (ld_data)       nxt = HAVE_DATA;
                else if (ld_ctrl)       nxt = HAVE_CTRL;
            end
            HAVE_DATA: if (ld_ctrl) nxt = READY;
            HAVE_CTRL: if (ld_data) nxt = READY;
            default:   nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shifter_operand_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : shifter_loader_if
// Description : Board-side switch/button inputs and operand outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface shifter_loader_if;
    logic [1:32] sw;
    logic [1:4]  swb;
    logic [31:0] shift_data;
    logic [2:0]  shift_op;
    logic [7:0]  shift_num;
    logic        carry_flag;
    logic        operands_valid;
    logic        update;
    logic [1:0]  state;

    modport master (
        output sw, swb,
        input  shift_data, shift_op, shift_num, carry_flag, operands_valid, update, state
    );

    modport slave (
        input  sw, swb,
        output shift_data, shift_op, shift_num, carry_flag, operands_valid, update, state
    );
endinterface
`default_nettype wire

// File: rtl/shifter_operand_loader_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchroniser, counter debounce and registered
//               rising-edge press detect for one push-button.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter bit PULSE_OUT       = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic raw,
    output logic      out
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic             r_deb_q;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_deb_q <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_deb_q <= r_deb;
            r_press <= r_deb & ~r_deb_q;
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Level-type buttons (carry) expose the debounced level instead of a pulse.
    assign out = PULSE_OUT ? r_press : r_deb;

endmodule
`default_nettype wire

// File: rtl/shifter_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : shifter_operand_loader
// Description : Debounces the board buttons and sequences loading of the
//               barrel-shifter operands from the slide switches.
// Revision    : 1.0 - initial release
// ============================================================================
module shifter_operand_loader
    import shifter_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  wire logic        clk,
    input  wire logic        rst,
    shifter_loader_if.slave  bus
);

    logic [1:4]  w_btn;
    logic        w_ld_data;
    logic        w_ld_ctrl;
    logic        w_clr;
    state_t      w_next;

    state_t      r_state;
    logic [31:0] r_data;
    logic [2:0]  r_op;
    logic [7:0]  r_num;
    logic        r_carry;
    logic        r_valid;
    logic        r_update;

    generate
        for (genvar gi = 1; gi <= 4; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W),
                .PULSE_OUT       (gi != BTN_CARRY)
            ) u_debounce (
                .clk (clk),
                .rst (rst),
                .raw (bus.swb[gi]),
                .out (w_btn[gi])
            );
        end
    endgenerate

    assign w_ld_data = w_btn[BTN_DATA];
    assign w_ld_ctrl = w_btn[BTN_CTRL];
    assign w_clr     = w_btn[BTN_CLR];
    assign w_next    = load_next_state(r_state, w_ld_data, w_ld_ctrl);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= EMPTY;
            r_data   <= '0;
            r_op     <= '0;
            r_num    <= '0;
            r_carry  <= 1'b0;
            r_valid  <= 1'b0;
            r_update <= 1'b0;
        end else begin
            r_carry  <= w_btn[BTN_CARRY];
            r_update <= w_clr | w_ld_data | w_ld_ctrl;
            // Clear outranks any load arriving in the same cycle.
            if (w_clr) begin
                r_state <= EMPTY;
                r_data  <= '0;
                r_op    <= '0;
                r_num   <= '0;
                r_valid <= 1'b0;
            end else begin
                if (w_ld_data) begin
                    r_data <= bus.sw;
                end
                if (w_ld_ctrl) begin
                    r_op  <= bus.sw[OP_MSB_SW:OP_LSB_SW];
                    r_num <= bus.sw[NUM_MSB_SW:NUM_LSB_SW];
                end
                r_state <= w_next;
                r_valid <= (w_next == READY);
            end
        end
    end

    assign bus.shift_data     = r_data;
    assign bus.shift_op       = r_op;
    assign bus.shift_num      = r_num;
    assign bus.carry_flag     = r_carry;
    assign bus.operands_valid = r_valid;
    assign bus.update         = r_update;
    assign bus.state          = r_state;

endmodule
`default_nettype wire

// File: tb/tb_shifter_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_shifter_operand_loader
// Description : Directed table-driven bench for the operand loader with
//               DEBOUNCE_CYCLES=4 plus hand sequences for bounce/carry/reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shifter_operand_loader;

    typedef struct {
        logic [1:32] sw;
        logic [1:4]  mask;
        logic [31:0] data;
        logic [2:0]  op;
        logic [7:0]  num;
        logic [1:0]  st;
    } vec_t;

    localparam int NVEC = 11;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] e_data;
    logic [2:0]  e_op;
    logic [7:0]  e_num;
    logic [1:0]  e_st;

    vec_t vecs [NVEC];

    shifter_loader_if bus ();

    shifter_operand_loader #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_data"},  bus.shift_data, e_data);
        chk({tag, "_op"},    32'(bus.shift_op), 32'(e_op));
        chk({tag, "_num"},   32'(bus.shift_num), 32'(e_num));
        chk({tag, "_state"}, 32'(bus.state), 32'(e_st));
        chk({tag, "_valid"}, 32'(bus.operands_valid), 32'(e_st == 2'd3));
    endtask

    // Press the masked buttons for 10 cycles; result must appear at cycle 8.
    task automatic apply_vec(input vec_t v);
        int upd_cnt;
        int upd_at;
        upd_cnt = 0;
        upd_at  = -1;
        @(negedge clk);
        bus.sw  = v.sw;
        bus.swb = bus.swb | v.mask;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (bus.update) begin
                upd_cnt++;
                upd_at = c;
            end
            if (c == 7) begin
                chk("pre_data", bus.shift_data, e_data);
                chk("pre_state", 32'(bus.state), 32'(e_st));
            end
            if (c == 8) begin
                e_data = v.data;
                e_op   = v.op;
                e_num  = v.num;
                e_st   = v.st;
                chk_outputs("vec");
                chk("vec_carry", 32'(bus.carry_flag), 32'd0);
            end
        end
        @(negedge clk);
        bus.swb = bus.swb & ~v.mask;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.update) upd_cnt++;
        end
        chk("upd_count", 32'(upd_cnt), 32'd1);
        chk("upd_cycle", 32'(upd_at), 32'd8);
        chk_outputs("hold");
    endtask

    task automatic bounce_seq();
        int upd_cnt;
        upd_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus.sw     = 32'hFFFF_FFFF;
            bus.swb[1] = (c < 20) && ((c % 4) < 2);
            @(posedge clk); #1;
            if (bus.update) upd_cnt++;
        end
        chk("bounce_upd", 32'(upd_cnt), 32'd0);
        chk_outputs("bounce");
    endtask

    task automatic carry_seq();
        int upd_cnt;
        upd_cnt = 0;
        @(negedge clk);
        bus.swb[3] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (bus.update) upd_cnt++;
            if (c == 6) chk("carry_rise_early", 32'(bus.carry_flag), 32'd0);
            if (c == 7) chk("carry_rise", 32'(bus.carry_flag), 32'd1);
        end
        @(negedge clk);
        bus.swb[3] = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (bus.update) upd_cnt++;
            if (c == 6) chk("carry_fall_early", 32'(bus.carry_flag), 32'd1);
            if (c == 7) chk("carry_fall", 32'(bus.carry_flag), 32'd0);
        end
        chk("carry_upd", 32'(upd_cnt), 32'd0);
        chk_outputs("carry");
    endtask

    // Reset lands when the ctrl button counter has reached 2.
    task automatic reset_seq();
        int upd_cnt;
        upd_cnt = 0;
        @(negedge clk);
        bus.swb[2] = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst        = 1'b1;
        bus.swb[2] = 1'b0;
        @(posedge clk); #1;
        e_data = '0;
        e_op   = '0;
        e_num  = '0;
        e_st   = 2'd0;
        chk_outputs("rst");
        chk("rst_update", 32'(bus.update), 32'd0);
        chk("rst_carry", 32'(bus.carry_flag), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.update) upd_cnt++;
        end
        chk("rst_no_press", 32'(upd_cnt), 32'd0);
        chk_outputs("post_rst");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        e_data = '0;
        e_op   = '0;
        e_num  = '0;
        e_st   = 2'd0;

        vecs[0]  = '{32'h8000_0001, 4'b1000, 32'h8000_0001, 3'd0, 8'h00, 2'd1};
        vecs[1]  = '{32'h6005_0000, 4'b0100, 32'h8000_0001, 3'd3, 8'h05, 2'd3};
        vecs[2]  = '{32'hFFFF_FFFF, 4'b1001, 32'h0000_0000, 3'd0, 8'h00, 2'd0};
        vecs[3]  = '{32'hE0FF_0000, 4'b0100, 32'h0000_0000, 3'd7, 8'hFF, 2'd2};
        vecs[4]  = '{32'h2001_0000, 4'b0100, 32'h0000_0000, 3'd1, 8'h01, 2'd2};
        vecs[5]  = '{32'h1234_5678, 4'b1000, 32'h1234_5678, 3'd1, 8'h01, 2'd3};
        vecs[6]  = '{32'hDEAD_BEEF, 4'b1000, 32'hDEAD_BEEF, 3'd1, 8'h01, 2'd3};
        vecs[7]  = '{32'h0000_0000, 4'b0001, 32'h0000_0000, 3'd0, 8'h00, 2'd0};
        vecs[8]  = '{32'hA5A5_5A5A, 4'b1100, 32'hA5A5_5A5A, 3'd5, 8'hA5, 2'd3};
        vecs[9]  = '{32'h4023_0000, 4'b0100, 32'h0000_0000, 3'd2, 8'h23, 2'd2};
        vecs[10] = '{32'h0000_0000, 4'b0001, 32'h0000_0000, 3'd0, 8'h00, 2'd0};

        rst     = 1'b1;
        bus.sw  = '0;
        bus.swb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        begin
            int upd_cnt;
            upd_cnt = 0;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                if (bus.update) upd_cnt++;
            end
            chk("idle_upd", 32'(upd_cnt), 32'd0);
            chk_outputs("reset");
            chk("reset_carry", 32'(bus.carry_flag), 32'd0);
        end

        for (int i = 0; i < NVEC; i++) begin
            if (i == 2) bounce_seq();
            if (i == 3) carry_seq();
            if (i == 9) reset_seq();
            apply_vec(vecs[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shifter_operand_loader.md
Name: shifter_operand_loader

Overview:
- Input-side front end for the board-level barrel-shifter experiment.
- Conditions the raw board push-buttons: 2-flop synchroniser, debounce, rising-edge detect.
- Sequences loading of the shifter operands (data word, op code, shift count, carry-in) from the 32 slide switches.
- Presents registered, stable operands plus a validity flag and an update pulse to the barrelshifter32 instance and status LEDs.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive cycles a synchronised button must differ from its debounced value before the debounced value flips (10 ms at 50 MHz).
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk, input, 1: system clock; the only clock.
- rst, input, 1: synchronous, active-high reset.
- sw, input, [1:32]: slide switches; sw[1] is the MSB of the data word.
- swb, input, [1:4]: raw buttons.
  - swb[1]: load data.
  - swb[2]: load control.
  - swb[3]: carry level.
  - swb[4]: clear.
- shift_data, output, 32: operand word.
- shift_op, output, 3: SHIFT_OP code.
- shift_num, output, 8: shift amount.
- carry_flag, output, 1: debounced carry-in level.
- operands_valid, output, 1: high when state is READY.
- update, output, 1: one-cycle pulse whenever any operand register was written.
- state, output, 2: FSM state, for LEDs.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All outputs are 0; state = EMPTY.
  - Synchronisers, debounced levels and counters are 0.
  - rst has priority over everything.
- Debounce, per button:
  - sync2 = two-flop synchronised raw input.
  - If sync2 != deb: counter increments. If sync2 == deb: counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, deb takes sync2 on that edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Press pulse: press[i] = deb[i] & ~deb_q[i]; exactly one cycle per debounced rising edge. Releases generate nothing.
- Latency: a raw rising edge held steady at cycle 0 yields press at cycle DEBOUNCE_CYCLES+3. Registers, state and the update pulse change on the following edge (cycle DEBOUNCE_CYCLES+4).
- Capture: sw is sampled in the press cycle.
  - load data: shift_data[31:0] <= sw[1:32].
  - load control: shift_op[2:0] <= sw[1:3]; shift_num[7:0] <= sw[9:16].
- carry_flag = deb[3] (level, not a press); updates with debounce latency only; does not assert update.
- FSM states (encoding): EMPTY=0, HAVE_DATA=1, HAVE_CTRL=2, READY=3.
  - EMPTY: data press -> HAVE_DATA; ctrl press -> HAVE_CTRL; both in the same cycle -> READY.
  - HAVE_DATA: ctrl press -> READY; data press -> overwrite data, stay.
  - HAVE_CTRL: data press -> READY; ctrl press -> overwrite control, stay.
  - READY: any load press overwrites the corresponding register and stays READY.
- update: asserted one cycle after any load press, in any state.
- Clear press:
  - Any state -> EMPTY; shift_data, shift_op and shift_num <= 0.
  - update pulses.
  - Clear wins over load presses in the same cycle; those loads are discarded.
  - carry_flag is unaffected.
- Holding a button produces a single press. Re-press requires release and re-debounce.
- sw changes without a press have no effect on outputs.

Decomposition:
- Package shifter_loader_pkg:
  - State enum/localparams (EMPTY, HAVE_DATA, HAVE_CTRL, READY).
  - Button index constants (BTN_DATA=1, BTN_CTRL=2, BTN_CARRY=3, BTN_CLR=4).
  - sw field bounds: op sw[1:3], num sw[9:16].
- Sub-module btn_debounce (synchroniser + counter + deb + press), parameterised by DEBOUNCE_CYCLES/CNT_W, instantiated 4 times.
- The top module holds the FSM and operand registers.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset, then idle 20 cycles:
  - all outputs 0, state=0, no update pulse.
- sw=32'h8000_0001, press swb[1] held 10 cycles:
  - shift_data=32'h8000_0001 at cycle 8 after press start.
  - state=1; update high exactly 1 cycle; operands_valid=0.
- Then sw[1:3]=3'b011, sw[9:16]=8'd5, press swb[2]:
  - shift_op=3, shift_num=5, state=3, operands_valid=1, one update pulse.
- Bounce swb[1] high 2 cycles / low 2 cycles ×5, with sw changed to 32'hFFFF_FFFF:
  - shift_data is unchanged, no update pulse.
- In READY, swb[4] and swb[1] rise in the same cycle:
  - state=0; data, op and num are 0; one update pulse; the load is discarded.
- Hold swb[3] high 10 cycles, then low:
  - carry_flag rises 7 cycles after the edge and falls 7 cycles after release.
  - No update pulse; state unchanged.
- Assert rst mid-debounce (counter=2) on swb[2]:
  - everything is 0 next edge; no later press pulse unless the button is re-held ≥ DEBOUNCE_CYCLES.
